pc_unit: RTL

//  Parametrised program-counter unit for the MIPS core; successor to the plain PC register.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ras.sv | 69 ++++++
 rtl/pc_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the program-counter unit.
package pc_pkg;

  localparam int          ADDR_WIDTH_DEF   = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam int          PC_INC           = 4;

  // Source of the next fetch PC.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_EXC = 2'd3
  } next_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry; a pop on an empty stack is ignored. Push and pop together
// replace the top entry (or create one when empty).
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_en;
  logic             empty;
  logic             full;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_W'(DEPTH));
  assign valid_o = !empty;
  assign top_o   = empty ? '0 : mem_q[top_q];

  // Pointer/occupancy update and write-slot selection.
  always_comb begin
    top_d  = top_q;
    occ_d  = occ_q;
    wr_en  = 1'b0;
    wr_ptr = top_q;
    if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (empty) occ_d = OCC_W'(1);
    end else if (push_i) begin
      top_d  = top_q + PTR_W'(1);
      wr_ptr = top_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (!full) occ_d = occ_q + OCC_W'(1);
    end else if (pop_i && !empty) begin
      top_d = top_q - PTR_W'(1);
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Pointer and occupancy registers, falling-edge clocked.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      occ_q <= '0;
    end else begin
      top_q <= top_d;
      occ_q <= occ_d;
    end
  end

  // Entry storage; contents are masked by occupancy so no reset is needed.
  always_ff @(negedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC register, next-PC selection with
// exception/stall priority, misaligned-target trap, RAS and a saturating
// RAS-mispredict counter. All state changes on the falling clock edge.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF),
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(EXC_VECTOR_DEF),
  parameter int                    RAS_DEPTH    = 4,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  exception,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] ras_top,
  output logic                  ras_valid,
  output logic                  misaligned,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misaligned_q, misaligned_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  next_sel_e             sel;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  ras_en, ras_push, ras_pop, mispredict;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(PC_INC);

  // RAS only moves on an edge that actually advances the pipeline.
  assign ras_en   = !stall && !exception;
  assign ras_push = ras_en && call;
  assign ras_pop  = ras_en && ret;

  // A pop with nothing predicted, or a prediction that disagrees with the
  // actual return register, is a mispredict.
  assign mispredict = ras_pop && (!ras_valid || (ras_top != jump_target));

  // Next-PC source selection (exception beats everything, stall handled below).
  always_comb begin
    sel = SEL_SEQ;
    if (exception)         sel = SEL_EXC;
    else if (branch_taken) sel = SEL_BR;
    else if (jump)         sel = SEL_JMP;
  end

  // Next PC, misaligned trap and counter update.
  always_comb begin
    redirect_target = branch_taken ? branch_target : jump_target;
    misaligned_d    = !exception && !stall &&
                      ((sel == SEL_BR) || (sel == SEL_JMP)) &&
                      (redirect_target[1:0] != 2'b00);
    pc_d = pc_plus4;
    case (sel)
      SEL_EXC: pc_d = EXC_VECTOR;
      SEL_BR:  pc_d = branch_target;
      SEL_JMP: pc_d = jump_target;
      default: pc_d = pc_plus4;
    endcase
    if (!exception && stall) pc_d = pc_q;
    else if (misaligned_d)   pc_d = EXC_VECTOR;
    cnt_d = cnt_q;
    if (mispredict && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // PC, trap flag and counter registers.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pc_out           = pc_q;
  assign misaligned       = misaligned_q;
  assign mispredict_count = cnt_q;

  pc_ras #(
    .W     (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clock),
    .rst_n   (reset_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_plus4),
    .top_o   (ras_top),
    .valid_o (ras_valid)
  );

endmodule
